// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single shared memory bus, one transaction in flight.
// Data wins ties unless fetch has been passed over STARVE_LIM consecutive times.
module mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_LIM = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic          m_ack,
    input  logic [DW-1:0] m_rdata,
    output logic          stall
);

    typedef enum logic [1:0] {
        IDLE,
        I_BUSY,
        D_BUSY
    } stateType;

    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIM);

    stateType   state;
    stateType   nextState;
    logic [2:0] starveCnt;
    logic       iElig;
    logic       dElig;
    logic       grantI;
    logic       grantD;
    logic       iComplete;
    logic       dComplete;

    // A requester whose done is showing is still holding req from the finished transaction.
    assign iElig     = i_req & ~i_done;
    assign dElig     = d_req & ~d_done;
    assign iComplete = (state == I_BUSY) && m_ack;
    assign dComplete = (state == D_BUSY) && m_ack;

    assign m_req = (state != IDLE);
    assign stall = (i_req & ~i_done) | (d_req & ~d_done);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        nextState = state;
        grantI    = 1'b0;
        grantD    = 1'b0;
        unique case (state)
            IDLE: begin
                if (dElig && !(iElig && starveCnt == STARVE_MAX)) begin
                    grantD    = 1'b1;
                    nextState = D_BUSY;
                end else if (iElig) begin
                    grantI    = 1'b1;
                    nextState = I_BUSY;
                end
            end
            I_BUSY:  if (m_ack) nextState = IDLE;
            D_BUSY:  if (m_ack) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            m_we      <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            starveCnt <= '0;
        end else begin
            // NOTE: non-blocking so every register here sees the pre-edge values of the others.
            state  <= nextState;
            i_done <= iComplete;
            d_done <= dComplete;

            if (grantI) begin
                m_addr  <= i_addr;
                m_we    <= 1'b0;
                m_wdata <= '0;
            end else if (grantD) begin
                m_addr  <= d_addr;
                m_we    <= d_we;
                m_wdata <= d_wdata;
            end

            if (iComplete) i_rdata <= m_rdata;
            if (dComplete && !m_we) d_rdata <= m_rdata;

            if (grantI) begin
                starveCnt <= '0;
            end else if (grantD && i_req && starveCnt != STARVE_MAX) begin
                starveCnt <= starveCnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change and outputs are sampled on the falling edge,
// the memory side is played by each scenario task with hand-computed responses.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_done;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic        stall;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(32), .DW(32), .STARVE_LIM(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_done  (i_done),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_done  (d_done),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_ack   (m_ack),
        .m_rdata (m_rdata),
        .stall   (stall)
    );

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL reset_m_req: got %b want 0", m_req); end
        checks++; if (m_we !== 1'b0) begin errors++; $display("FAIL reset_m_we: got %b want 0", m_we); end
        checks++; if ({i_done, d_done} !== 2'b00) begin errors++; $display("FAIL reset_done: got %b want 00", {i_done, d_done}); end
        checks++; if ({m_addr, m_wdata, i_rdata, d_rdata} !== 128'h0) begin errors++; $display("FAIL reset_data: got %h want 0", {m_addr, m_wdata, i_rdata, d_rdata}); end
        checks++; if (dut.starveCnt !== 3'd0) begin errors++; $display("FAIL reset_starve: got %0d want 0", dut.starveCnt); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Fetch with one wait state before the ack.
    task automatic test_lone_fetch();
        i_req = 1'b1; i_addr = 32'h100;
        @(negedge clk);
        checks++; if (m_req !== 1'b1 || m_addr !== 32'h100 || m_we !== 1'b0 || m_wdata !== 32'h0) begin errors++; $display("FAIL fetch_issue: got req=%b addr=%h we=%b wd=%h want 1/100/0/0", m_req, m_addr, m_we, m_wdata); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fetch_stall: got %b want 1", stall); end
        @(negedge clk);
        checks++; if (m_req !== 1'b1 || m_addr !== 32'h100 || i_done !== 1'b0) begin errors++; $display("FAIL fetch_wait: got req=%b addr=%h done=%b want 1/100/0", m_req, m_addr, i_done); end
        m_ack = 1'b1; m_rdata = 32'h00500093;
        @(negedge clk);
        m_ack = 1'b0; m_rdata = 32'h0;
        checks++; if (i_done !== 1'b1 || i_rdata !== 32'h00500093) begin errors++; $display("FAIL fetch_done: got done=%b rdata=%h want 1/00500093", i_done, i_rdata); end
        checks++; if (m_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL fetch_release: got req=%b stall=%b want 0/0", m_req, stall); end
        i_req = 1'b0;
        @(negedge clk);
        checks++; if (i_done !== 1'b0 || m_req !== 1'b0 || i_rdata !== 32'h00500093) begin errors++; $display("FAIL fetch_after: got done=%b req=%b rdata=%h want 0/0/00500093", i_done, m_req, i_rdata); end
    endtask

    // Load acked in its first m_req cycle: done two cycles after the request is seen.
    task automatic test_min_latency_load();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        @(negedge clk);
        checks++; if (m_req !== 1'b1 || m_we !== 1'b0 || m_addr !== 32'h40) begin errors++; $display("FAIL load_issue: got req=%b we=%b addr=%h want 1/0/40", m_req, m_we, m_addr); end
        m_ack = 1'b1; m_rdata = 32'h12345678;
        @(negedge clk);
        m_ack = 1'b0; m_rdata = 32'h0;
        checks++; if (d_done !== 1'b1 || d_rdata !== 32'h12345678 || m_req !== 1'b0) begin errors++; $display("FAIL load_done: got done=%b rdata=%h req=%b want 1/12345678/0", d_done, d_rdata, m_req); end
        d_req = 1'b0;
        @(negedge clk);
        checks++; if (d_done !== 1'b0) begin errors++; $display("FAIL load_pulse: got %b want 0", d_done); end
    endtask

    task automatic test_simultaneous();
        i_req = 1'b1; i_addr = 32'h104;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++; if (m_req !== 1'b1 || m_we !== 1'b1 || m_addr !== 32'h2000 || m_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL simul_store: got req=%b we=%b addr=%h wd=%h want 1/1/2000/deadbeef", m_req, m_we, m_addr, m_wdata); end
        m_ack = 1'b1; m_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        m_ack = 1'b0; m_rdata = 32'h0;
        checks++; if (d_done !== 1'b1 || m_req !== 1'b0 || i_done !== 1'b0) begin errors++; $display("FAIL simul_store_done: got dd=%b req=%b id=%b want 1/0/0", d_done, m_req, i_done); end
        checks++; if (d_rdata !== 32'h12345678) begin errors++; $display("FAIL simul_rdata_kept: got %h want 12345678", d_rdata); end
        checks++; if (dut.starveCnt !== 3'd1) begin errors++; $display("FAIL simul_starve_inc: got %0d want 1", dut.starveCnt); end
        d_req = 1'b0;
        @(negedge clk);
        checks++; if (m_req !== 1'b1 || m_we !== 1'b0 || m_addr !== 32'h104 || m_wdata !== 32'h0) begin errors++; $display("FAIL simul_fetch: got req=%b we=%b addr=%h wd=%h want 1/0/104/0", m_req, m_we, m_addr, m_wdata); end
        checks++; if (dut.starveCnt !== 3'd0) begin errors++; $display("FAIL simul_starve_clr: got %0d want 0", dut.starveCnt); end
        m_ack = 1'b1; m_rdata = 32'h00000013;
        @(negedge clk);
        m_ack = 1'b0; m_rdata = 32'h0;
        checks++; if (i_done !== 1'b1 || i_rdata !== 32'h00000013) begin errors++; $display("FAIL simul_fetch_done: got done=%b rdata=%h want 1/00000013", i_done, i_rdata); end
        i_req = 1'b0;
        @(negedge clk);
    endtask

    // Ack held off for three m_req cycles, arriving in the fourth.
    task automatic test_wait_states();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (m_req !== 1'b1 || m_addr !== 32'h300 || stall !== 1'b1 || d_done !== 1'b0) begin errors++; $display("FAIL wait_cycle%0d: got req=%b addr=%h stall=%b done=%b want 1/300/1/0", c, m_req, m_addr, stall, d_done); end
        end
        m_ack = 1'b1; m_rdata = 32'hCAFEF00D;
        @(negedge clk);
        m_ack = 1'b0; m_rdata = 32'h0;
        checks++; if (d_done !== 1'b1 || d_rdata !== 32'hCAFEF00D || m_req !== 1'b0) begin errors++; $display("FAIL wait_done: got done=%b rdata=%h req=%b want 1/cafef00d/0", d_done, d_rdata, m_req); end
        d_req = 1'b0;
        @(negedge clk);
    endtask

    // Both sides present together each round; fetch withdraws after losing, because a fetch
    // still held at data completion would be granted in that idle cycle and reset the count.
    task automatic test_starvation();
        for (int k = 0; k < 5; k++) begin
            i_req = 1'b1; i_addr = 32'h500;
            d_req = 1'b1; d_we = 1'b1; d_addr = 32'h600 + 32'(k * 4); d_wdata = 32'hA0 + 32'(k);
            @(negedge clk);
            if (k < 4) begin
                checks++; if (m_req !== 1'b1 || m_we !== 1'b1 || m_addr !== d_addr) begin errors++; $display("FAIL starve_data%0d: got req=%b we=%b addr=%h want 1/1/%h", k, m_req, m_we, m_addr, d_addr); end
                checks++; if (dut.starveCnt !== 3'(k + 1)) begin errors++; $display("FAIL starve_cnt%0d: got %0d want %0d", k, dut.starveCnt, k + 1); end
                i_req = 1'b0; m_ack = 1'b1;
                @(negedge clk);
                m_ack = 1'b0;
                checks++; if (d_done !== 1'b1) begin errors++; $display("FAIL starve_ddone%0d: got %b want 1", k, d_done); end
                d_req = 1'b0;
                @(negedge clk);
            end else begin
                checks++; if (m_req !== 1'b1 || m_we !== 1'b0 || m_addr !== 32'h500) begin errors++; $display("FAIL starve_fetch: got req=%b we=%b addr=%h want 1/0/500", m_req, m_we, m_addr); end
                checks++; if (dut.starveCnt !== 3'd0) begin errors++; $display("FAIL starve_clear: got %0d want 0", dut.starveCnt); end
                m_ack = 1'b1; m_rdata = 32'h00000513;
                @(negedge clk);
                m_ack = 1'b0; m_rdata = 32'h0;
                checks++; if (i_done !== 1'b1 || i_rdata !== 32'h00000513) begin errors++; $display("FAIL starve_idone: got done=%b rdata=%h want 1/00000513", i_done, i_rdata); end
                i_req = 1'b0; d_req = 1'b0;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_held_request();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700;
        @(negedge clk);
        m_ack = 1'b1; m_rdata = 32'h77;
        @(negedge clk);
        m_ack = 1'b0; m_rdata = 32'h0;
        checks++; if (d_done !== 1'b1 || d_rdata !== 32'h77) begin errors++; $display("FAIL held_done: got done=%b rdata=%h want 1/77", d_done, d_rdata); end
        @(negedge clk);
        checks++; if (m_req !== 1'b0 || d_done !== 1'b0) begin errors++; $display("FAIL held_no_regrant: got req=%b done=%b want 0/0", m_req, d_done); end
        d_req = 1'b0;
        @(negedge clk);
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL held_idle: got req=%b want 0", m_req); end
    endtask

    task automatic test_drop_and_idle_ack();
        i_req = 1'b1; i_addr = 32'h800;
        @(negedge clk);
        i_req = 1'b0;
        @(negedge clk);
        checks++; if (m_req !== 1'b1 || m_addr !== 32'h800) begin errors++; $display("FAIL drop_keep: got req=%b addr=%h want 1/800", m_req, m_addr); end
        m_ack = 1'b1; m_rdata = 32'h88;
        @(negedge clk);
        m_ack = 1'b0; m_rdata = 32'h0;
        checks++; if (i_done !== 1'b1 || i_rdata !== 32'h88) begin errors++; $display("FAIL drop_done: got done=%b rdata=%h want 1/88", i_done, i_rdata); end
        @(negedge clk);
        m_ack = 1'b1; m_rdata = 32'hBAD;
        @(negedge clk);
        m_ack = 1'b0; m_rdata = 32'h0;
        checks++; if ({i_done, d_done, m_req} !== 3'b000 || i_rdata !== 32'h88) begin errors++; $display("FAIL idle_ack: got id/dd/req=%b rdata=%h want 000/88", {i_done, d_done, m_req}, i_rdata); end
    endtask

    task automatic test_reset_mid();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h900; d_wdata = 32'h55;
        @(negedge clk);
        checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL rstmid_busy: got %b want 1", m_req); end
        #2 rst = 1'b1;
        #1;
        checks++; if (m_req !== 1'b0 || m_we !== 1'b0 || m_addr !== 32'h0 || m_wdata !== 32'h0) begin errors++; $display("FAIL rstmid_async: got req=%b we=%b addr=%h wd=%h want all 0", m_req, m_we, m_addr, m_wdata); end
        d_req = 1'b0;
        @(negedge clk);
        rst = 1'b0; m_ack = 1'b1; m_rdata = 32'h99;
        @(negedge clk);
        m_ack = 1'b0; m_rdata = 32'h0;
        checks++; if ({i_done, d_done, m_req, m_we} !== 4'b0000) begin errors++; $display("FAIL rstmid_ack_ignored: got id/dd/req/we=%b want 0000", {i_done, d_done, m_req, m_we}); end
        checks++; if ({m_addr, m_wdata, i_rdata, d_rdata} !== 128'h0 || dut.starveCnt !== 3'd0) begin errors++; $display("FAIL rstmid_cleared: got %h starve=%0d want 0", {m_addr, m_wdata, i_rdata, d_rdata}, dut.starveCnt); end
        @(negedge clk);
        checks++; if (d_done !== 1'b0 || m_req !== 1'b0) begin errors++; $display("FAIL rstmid_quiet: got dd=%b req=%b want 0/0", d_done, m_req); end
    endtask

    initial begin
        rst = 1'b1;
        i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        m_ack = 1'b0; m_rdata = 32'h0;
        test_reset();
        test_lone_fetch();
        test_min_latency_load();
        test_simultaneous();
        test_wait_states();
        test_starvation();
        test_held_request();
        test_drop_and_idle_ack();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
